// File: rtl/sine_wg_nco.sv
// sine_wg_nco: multichannel numerically controlled sine oscillator.
// Each channel owns a phase accumulator and a phase step. A tick runs one
// frame that emits one interpolated quarter-wave-table sample per channel,
// tagged with its channel number. The accumulator of a channel advances when
// that channel's sample is accepted downstream.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_cfg_d/ch/phase     config write: signed value, channel, 1=phase 0=step
//   s_cfg_dv/s_cfg_dr    config handshake (ready only while idle)
//   tick                 single-cycle frame start strobe
//   m_sine_d/ch          sample and its channel
//   m_sine_dv/m_sine_dr  sample handshake
//   m_cos_d              cosine of the same phase (SINE_WG_NCO_COSINE_EN only)
//   overrun              sticky: tick seen while a frame was running
//
// Build option: define SINE_WG_NCO_COSINE_EN to add the m_cos_d output.
module sine_wg_nco #(
    parameter int unsigned NR_CHANNELS    = 4,
    parameter int unsigned RADIAN_WIDTH   = 24,
    parameter int unsigned SINE_WIDTH     = 24,
    parameter int unsigned TBL_ADDR_WIDTH = 8,
    localparam int unsigned CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [RADIAN_WIDTH-1:0] s_cfg_d,
    input  logic [CH_W-1:0]                s_cfg_ch,
    input  logic                           s_cfg_phase,
    input  logic                           s_cfg_dv,
    output logic                           s_cfg_dr,
    input  logic                           tick,
    output logic signed [SINE_WIDTH-1:0]   m_sine_d,
    output logic [CH_W-1:0]                m_sine_ch,
    output logic                           m_sine_dv,
    input  logic                           m_sine_dr,
`ifdef SINE_WG_NCO_COSINE_EN
    output logic signed [SINE_WIDTH-1:0]   m_cos_d,
`endif
    output logic                           overrun
);

    localparam int unsigned FRAC  = 10;
    localparam int unsigned SH    = 32;
    localparam int unsigned TBL_N = 1 << TBL_ADDR_WIDTH;
    localparam int unsigned IDX_W = TBL_ADDR_WIDTH + 1;
    localparam int unsigned POS_W = TBL_ADDR_WIDTH + FRAC + 1;
    localparam int unsigned AW    = RADIAN_WIDTH + 2;
    localparam int unsigned PW    = SINE_WIDTH + FRAC + 2;

    localparam real    PI_R      = 3.14159265358979323846;
    localparam longint PI_L      = longint'(PI_R * real'(64'd1 << (RADIAN_WIDTH - 3)));
    localparam longint HALF_PI_L = PI_L / 2;
    // Fixed-point reciprocal of pi/2 mapping an angle onto table position units.
    localparam longint SCALE     =
        longint'(real'(64'd1 << (TBL_ADDR_WIDTH + FRAC + SH)) / real'(HALF_PI_L));
    localparam longint unsigned POS_MAX = 64'd1 << (TBL_ADDR_WIDTH + FRAC);

    localparam logic signed [AW-1:0] PI_A     = AW'(PI_L);
    localparam logic signed [AW-1:0] HALF_A   = AW'(HALF_PI_L);
    localparam logic signed [AW-1:0] TWO_PI_A = AW'(2 * PI_L);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOLD   = 3'd1,
        READ   = 3'd2,
        INTERP = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Quarter-wave sine table, 2^TBL_ADDR_WIDTH+1 points over [0, pi/2].
    logic signed [SINE_WIDTH-1:0] tbl [0:TBL_N];
    for (genvar k = 0; k <= TBL_N; k++) begin : g_tbl
        localparam real    ANG = PI_R * real'(k) / real'(64'd1 << (TBL_ADDR_WIDTH + 1));
        localparam longint VAL = longint'($sin(ANG) * real'(64'd1 << (SINE_WIDTH - 2)));
        assign tbl[k] = SINE_WIDTH'(VAL);
    end

    logic signed [RADIAN_WIDTH-1:0] acc_q  [NR_CHANNELS];
    logic signed [RADIAN_WIDTH-1:0] step_q [NR_CHANNELS];
    logic [CH_W-1:0]                ch_q;
    logic                           sign_q;
    logic [IDX_W-1:0]               idx_q;
    logic [FRAC-1:0]                frac_q;
    logic signed [SINE_WIDTH-1:0]   t0_q, t1_q;

    logic signed [AW-1:0] xs_c, mag_c, fold_c, adv_c, cfg_c;
    logic signed [AW-1:0] step_val_c, phase_val_c;
    logic [POS_W-1:0]     pos_c;
    logic [IDX_W-1:0]     idx_nx_c;
    logic                 cfg_wr_c, xfer_c, last_c;

    // Angle in [0, pi/2] to table position (index.fraction), clamped to the last entry.
    function automatic logic [POS_W-1:0] angle_to_pos(input logic [AW-1:0] a);
        longint unsigned p;
        p = (64'(a) * 64'(SCALE)) >> SH;
        if (p > POS_MAX) p = POS_MAX;
        return POS_W'(p);
    endfunction

    // Linear interpolation between two table entries, then optional negation.
    function automatic logic signed [SINE_WIDTH-1:0] interp(
        input logic signed [SINE_WIDTH-1:0] lo,
        input logic signed [SINE_WIDTH-1:0] hi,
        input logic [FRAC-1:0]              f,
        input logic                         neg
    );
        logic signed [PW-1:0] prod, y;
        prod = (PW'(hi) - PW'(lo)) * PW'($signed({1'b0, f}));
        y    = PW'(lo) + (prod >>> FRAC);
        if (neg) y = -y;
        return SINE_WIDTH'(y);
    endfunction

    // Phase fold, accumulator advance and config value conditioning.
    always_comb begin
        xs_c     = AW'(acc_q[ch_q]);
        mag_c    = xs_c[AW-1] ? -xs_c : xs_c;
        fold_c   = (mag_c > HALF_A) ? (PI_A - mag_c) : mag_c;
        pos_c    = angle_to_pos(fold_c);
        idx_nx_c = (idx_q == IDX_W'(TBL_N)) ? idx_q : idx_q + 1'b1;

        adv_c = xs_c + AW'(step_q[ch_q]);
        if (adv_c > PI_A)       adv_c = adv_c - TWO_PI_A;
        else if (adv_c < -PI_A) adv_c = adv_c + TWO_PI_A;

        cfg_c       = AW'(s_cfg_d);
        step_val_c  = cfg_c;
        phase_val_c = cfg_c;
        if (cfg_c > PI_A) begin
            step_val_c  = PI_A;
            phase_val_c = cfg_c - TWO_PI_A;
        end else if (cfg_c < -PI_A) begin
            step_val_c  = -PI_A;
            phase_val_c = cfg_c + TWO_PI_A;
        end

        cfg_wr_c = (state_q == IDLE) && s_cfg_dv && (32'(s_cfg_ch) < NR_CHANNELS);
        xfer_c   = (state_q == OUT) && m_sine_dr;
        last_c   = (32'(ch_q) == NR_CHANNELS - 1);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = FOLD;
            FOLD:    state_d = READ;
            READ:    state_d = INTERP;
            INTERP:  state_d = OUT;
            OUT:     if (xfer_c) state_d = last_c ? IDLE : FOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Channel datapath, config storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < int'(NR_CHANNELS); n++) begin
                acc_q[n]  <= '0;
                step_q[n] <= '0;
            end
            ch_q      <= '0;
            sign_q    <= 1'b0;
            idx_q     <= '0;
            frac_q    <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            m_sine_d  <= '0;
            m_sine_ch <= '0;
            m_sine_dv <= 1'b0;
            s_cfg_dr  <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            s_cfg_dr <= (state_d == IDLE);
            if (tick && (state_q != IDLE)) overrun <= 1'b1;

            if (cfg_wr_c) begin
                if (s_cfg_phase) acc_q[s_cfg_ch]  <= RADIAN_WIDTH'(phase_val_c);
                else             step_q[s_cfg_ch] <= RADIAN_WIDTH'(step_val_c);
            end

            case (state_q)
                IDLE: if (tick) ch_q <= '0;
                FOLD: begin
                    sign_q <= xs_c[AW-1];
                    idx_q  <= pos_c[POS_W-1:FRAC];
                    frac_q <= pos_c[FRAC-1:0];
                end
                READ: begin
                    t0_q <= tbl[idx_q];
                    t1_q <= tbl[idx_nx_c];
                end
                INTERP: begin
                    m_sine_d  <= interp(t0_q, t1_q, frac_q, sign_q);
                    m_sine_ch <= ch_q;
                    m_sine_dv <= 1'b1;
                end
                OUT: if (xfer_c) begin
                    m_sine_dv    <= 1'b0;
                    acc_q[ch_q]  <= RADIAN_WIDTH'(adv_c);
                    ch_q         <= ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SINE_WG_NCO_COSINE_EN
    // Cosine path: second table read at pi/2 - folded angle, negative when |x| > pi/2.
    logic [POS_W-1:0]             cpos_c;
    logic [IDX_W-1:0]             cidx_nx_c;
    logic                         csign_q;
    logic [IDX_W-1:0]             cidx_q;
    logic [FRAC-1:0]              cfrac_q;
    logic signed [SINE_WIDTH-1:0] tc0_q, tc1_q;

    always_comb begin
        cpos_c    = angle_to_pos(HALF_A - fold_c);
        cidx_nx_c = (cidx_q == IDX_W'(TBL_N)) ? cidx_q : cidx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csign_q <= 1'b0;
            cidx_q  <= '0;
            cfrac_q <= '0;
            tc0_q   <= '0;
            tc1_q   <= '0;
            m_cos_d <= '0;
        end else begin
            case (state_q)
                FOLD: begin
                    csign_q <= (mag_c > HALF_A);
                    cidx_q  <= cpos_c[POS_W-1:FRAC];
                    cfrac_q <= cpos_c[FRAC-1:0];
                end
                READ: begin
                    tc0_q <= tbl[cidx_q];
                    tc1_q <= tbl[cidx_nx_c];
                end
                INTERP:  m_cos_d <= interp(tc0_q, tc1_q, cfrac_q, csign_q);
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sine_wg_nco.sv
// Self-checking bench for sine_wg_nco (4 channels, 24-bit phase and sample).
`timescale 1ns/1ps
module tb_sine_wg_nco;

    localparam int NR       = 4;
    localparam int PI_I     = 6588397;
    localparam int TWO_PI_I = 13176794;
    localparam int FULL     = 4194304;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] s_cfg_d;
    logic [1:0]         s_cfg_ch;
    logic               s_cfg_phase;
    logic               s_cfg_dv;
    logic               s_cfg_dr;
    logic               tick;
    logic signed [23:0] m_sine_d;
    logic [1:0]         m_sine_ch;
    logic               m_sine_dv;
    logic               m_sine_dr;
    logic               overrun;
`ifdef SINE_WG_NCO_COSINE_EN
    logic signed [23:0] m_cos_d;
`endif

    sine_wg_nco dut (
        .clk         (clk),
        .rst         (rst),
        .s_cfg_d     (s_cfg_d),
        .s_cfg_ch    (s_cfg_ch),
        .s_cfg_phase (s_cfg_phase),
        .s_cfg_dv    (s_cfg_dv),
        .s_cfg_dr    (s_cfg_dr),
        .tick        (tick),
        .m_sine_d    (m_sine_d),
        .m_sine_ch   (m_sine_ch),
        .m_sine_dv   (m_sine_dv),
        .m_sine_dr   (m_sine_dr),
`ifdef SINE_WG_NCO_COSINE_EN
        .m_cos_d     (m_cos_d),
`endif
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int val; int tol; } exp_t;
    typedef struct { int ch; bit phase; int d; int eff; int tol; } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;
    int   model_acc [NR];
    int   model_step[NR];
    int   last_val  [NR];

    // Ideal sine of a phase where 2^21 = 1 radian, scaled so 1.0 = 2^22.
    function automatic int ideal(input int ph);
        real r;
        r = $sin(real'(ph) / 2097152.0) * 4194304.0;
        if (r < 0.0) return -$rtoi(-r + 0.5);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int wrap_adv(input int a, input int s);
        int r;
        r = a + s;
        if (r > PI_I)       r = r - TWO_PI_I;
        else if (r < -PI_I) r = r + TWO_PI_I;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        sb_q.delete();
        for (int c = 0; c < NR; c++) begin
            model_acc[c]  = 0;
            model_step[c] = 0;
        end
    endtask

    task automatic cfg_write(input int ch, input bit phase, input int d);
        s_cfg_ch    = 2'(ch);
        s_cfg_phase = phase;
        s_cfg_d     = 24'(d);
        s_cfg_dv    = 1'b1;
        cycle();
        s_cfg_dv    = 1'b0;
    endtask

    // Queue one expected sample per channel, then advance the model accumulators.
    task automatic push_frame(input int tol);
        exp_t e;
        for (int c = 0; c < NR; c++) begin
            e.ch  = c;
            e.val = ideal(model_acc[c]);
            e.tol = tol;
            sb_q.push_back(e);
            model_acc[c] = wrap_adv(model_acc[c], model_step[c]);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || !s_cfg_dr) && k < 200) begin
            cycle();
            k++;
        end
        chk("frame_completes_in_budget", (k < 200) ? 1 : 0, 1);
    endtask

    task automatic tick_frame(input int tol);
        push_frame(tol);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        wait_done();
    endtask

    // Scoreboard consumer: every accepted sample is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && m_sine_dv && m_sine_dr) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample ch=%0d got=%0d required=no sample",
                         m_sine_ch, m_sine_d);
            end else begin
                mon_e = sb_q.pop_front();
                if (int'(m_sine_ch) != mon_e.ch ||
                    int'(m_sine_d) - mon_e.val > mon_e.tol ||
                    mon_e.val - int'(m_sine_d) > mon_e.tol) begin
                    failures++;
                    $display("FAIL sample ch=%0d got=%0d required ch=%0d value=%0d+/-%0d",
                             m_sine_ch, m_sine_d, mon_e.ch, mon_e.val, mon_e.tol);
                end
                last_val[mon_e.ch] = int'(m_sine_d);
            end
            checks++;
            if (int'(m_sine_d) > FULL + 32 || int'(m_sine_d) < -FULL - 32) begin
                failures++;
                $display("FAIL sample_range got=%0d required=|x|<=%0d", m_sine_d, FULL + 32);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  saw;
        logic signed [23:0] d0;
        logic [1:0]         c0;

        vecs[0] = '{1, 1'b1,  3294199,  3294199, 32};
        vecs[1] = '{2, 1'b1, -3294199, -3294199, 32};
        vecs[2] = '{0, 1'b1,  7000000, -6176794, 64};
        vecs[3] = '{3, 1'b1, -8000000,  5176794, 64};
        vecs[4] = '{1, 1'b1,  6588397,  6588397, 64};
        vecs[5] = '{0, 1'b0,  8000000,  6588397, 64};
        vecs[6] = '{3, 1'b0, -7000000, -6588397, 64};
        vecs[7] = '{2, 1'b0,  1000000,  1000000, 64};
        vecs[8] = '{1, 1'b0,    51472,    51472, 64};

        rst         = 1'b1;
        s_cfg_d     = '0;
        s_cfg_ch    = '0;
        s_cfg_phase = 1'b0;
        s_cfg_dv    = 1'b0;
        tick        = 1'b0;
        m_sine_dr   = 1'b1;
        do_reset();

        chk("reset_dv", m_sine_dv, 0);
        chk("reset_d", m_sine_d, 0);
        chk("reset_ch", m_sine_ch, 0);
        chk("reset_cfg_dr", s_cfg_dr, 1);
        chk("reset_overrun", overrun, 0);

        // Latency and spacing: samples at tick+4, +8, +12, +16.
        push_frame(0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("dv_timing", m_sine_dv, (i % 4 == 0) ? 1 : 0);
            cycle();
        end
        chk("cfg_dr_after_last", s_cfg_dr, 1);
        wait_done();

        // Table of config writes, each followed by one frame.
        for (int v = 0; v < 9; v++) begin
            cfg_write(vecs[v].ch, vecs[v].phase, vecs[v].d);
            if (vecs[v].phase) model_acc[vecs[v].ch]  = vecs[v].eff;
            else               model_step[vecs[v].ch] = vecs[v].eff;
            tick_frame(vecs[v].tol);
        end
        for (int f = 0; f < 6; f++) tick_frame(64);

        // Config and tick in the same cycle: frame uses the new phase.
        do_reset();
        model_acc[0] = 3294199;
        push_frame(32);
        s_cfg_ch    = 2'd0;
        s_cfg_phase = 1'b1;
        s_cfg_d     = 24'sd3294199;
        s_cfg_dv    = 1'b1;
        tick        = 1'b1;
        cycle();
        s_cfg_dv    = 1'b0;
        tick        = 1'b0;
        wait_done();

        // Backpressure on ch1 for 10 cycles with a stray tick inside the frame.
        do_reset();
        cfg_write(1, 1'b1, 3294199);
        model_acc[1] = 3294199;
        push_frame(32);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        k = 0;
        while (!(m_sine_dv && m_sine_ch == 2'd1) && k < 20) begin
            cycle();
            k++;
        end
        chk("stall_reach_ch1", (k < 20) ? 1 : 0, 1);
        m_sine_dr = 1'b0;
        tick      = 1'b1;
        d0        = m_sine_d;
        c0        = m_sine_ch;
        cycle();
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_dv", m_sine_dv, 1);
            chk("stall_d", m_sine_d, d0);
            chk("stall_ch", m_sine_ch, c0);
            cycle();
        end
        chk("overrun_set", overrun, 1);
        m_sine_dr = 1'b1;
        wait_done();
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (m_sine_dv) saw = 1'b1;
        end
        chk("no_extra_frame", saw, 0);
        chk("overrun_sticky", overrun, 1);

        // Reset during READ of ch2 aborts the frame and clears all state.
        do_reset();
        for (int c = 0; c < NR; c++) begin
            cfg_write(c, 1'b1, 1000000 * (c + 1));
            model_acc[c] = 1000000 * (c + 1);
        end
        cfg_write(0, 1'b0, 51472);
        model_step[0] = 51472;
        push_frame(64);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_dv", m_sine_dv, 0);
        chk("rst_mid_cfg_dr", s_cfg_dr, 1);
        chk("rst_mid_pending", sb_q.size(), 2);
        rst = 1'b0;
        sb_q.delete();
        for (int c = 0; c < NR; c++) begin
            model_acc[c]  = 0;
            model_step[c] = 0;
        end
        tick_frame(0);

        // Sweep ch0 at pi/128 per frame across a full turn.
        do_reset();
        cfg_write(0, 1'b0, 51472);
        model_step[0] = 51472;
        for (int n = 0; n <= 256; n++) begin
            tick_frame(64);
            if (n == 127) chk("sweep_127_positive", (last_val[0] > 0) ? 1 : 0, 1);
            if (n == 128) chk("sweep_128_negative", (last_val[0] < 0) ? 1 : 0, 1);
            if (n == 129) chk("sweep_129_negative", (last_val[0] < 0) ? 1 : 0, 1);
        end

`ifdef SINE_WG_NCO_COSINE_EN
        // Cosine output: phase 0 on ch0/2/3 gives +1.0, phase pi on ch1 gives -1.0.
        do_reset();
        cfg_write(1, 1'b1, PI_I);
        model_acc[1] = PI_I;
        push_frame(32);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_sine_dv) begin
                k++;
                checks++;
                if ((m_sine_ch == 2'd1 && (int'(m_cos_d) > -FULL + 32 || int'(m_cos_d) < -FULL - 32)) ||
                    (m_sine_ch != 2'd1 && (int'(m_cos_d) > FULL + 32 || int'(m_cos_d) < FULL - 32))) begin
                    failures++;
                    $display("FAIL cos ch=%0d got=%0d required=%0d+/-32", m_sine_ch, m_cos_d,
                             (m_sine_ch == 2'd1) ? -FULL : FULL);
                end
            end
            cycle();
        end
        chk("cos_sample_count", k, 4);
        wait_done();
`endif

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
